// File: rtl/noc_inject_sequencer.sv
// noc_inject_sequencer
//
// Drives the two-operand injection handshake (START, START2, DONE) of the
// NoC adder top. A sequence of CFG_NUM_PKT packets is issued back-to-back:
// START for one cycle, START2 for one cycle, then wait for a rising edge of
// DONE (watchdog-bounded), then GAP_CYCLES idle cycles before the next packet.
//
// Optional feature macro: INJ_LOG_EN
//   defined   : DATA_O1 is captured at the edge ending INJ1, DATA_O2 at the
//               edge ending INJ2; both are published together on
//               LOG_DATA1/LOG_DATA2 with a LOG_VALID pulse in the first
//               WAIT_DONE cycle.
//   undefined : no capture registers, LOG_* tied to 0.
//
// Parameters:
//   DATAW          operand width (matches TDATAW of the adder top)
//   GAP_CYCLES     idle cycles between DONE and the next START (>= 0)
//   TIMEOUT_CYCLES max WAIT_DONE cycles per packet (>= 1)
//   CNTW           width of packet count / counter
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   RUN                  start a sequence (sampled in IDLE only)
//   ABORT                end the sequence next cycle (any non-IDLE state)
//   CFG_NUM_PKT          packets per sequence, latched on RUN
//   START, START2        injection strobes to the adder top
//   DONE                 completion level from the adder top
//   DATA_O1, DATA_O2     operands presented by the adder top
//   BUSY                 high in every state except IDLE
//   FINISHED             one-cycle pulse when a sequence ends
//   TIMEOUT_ERR          sticky watchdog error, cleared on RUN
//   PKT_CNT              packets completed (saturating)
//   LOG_VALID/LOG_DATA1/LOG_DATA2  operand log output
module noc_inject_sequencer #(
  parameter int DATAW          = 32,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNTW           = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic             ABORT,
  input  logic [CNTW-1:0]  CFG_NUM_PKT,
  output logic             START,
  output logic             START2,
  input  logic             DONE,
  input  logic [DATAW-1:0] DATA_O1,
  input  logic [DATAW-1:0] DATA_O2,
  output logic             BUSY,
  output logic             FINISHED,
  output logic             TIMEOUT_ERR,
  output logic [CNTW-1:0]  PKT_CNT,
  output logic             LOG_VALID,
  output logic [DATAW-1:0] LOG_DATA1,
  output logic [DATAW-1:0] LOG_DATA2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INJ1,
    S_INJ2,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_e;

  localparam int              WDW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int              GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int              CW1      = CNTW + 1;
  localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   num_q, num_d;
  logic [CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              done_prev_q;
  logic              start_q, start_d;
  logic              start2_q, start2_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;

  logic              done_evt;
  logic              hit;
  logic              last_pkt;

  // Completion is the rising edge of the DONE level, not the level itself.
  assign done_evt = DONE & ~done_prev_q;
  // An edge seen during injection is remembered and consumed on WAIT_DONE.
  assign hit      = done_evt | pend_q;
  // Widened compare so a saturated counter can never alias onto the target.
  assign last_pkt = ({1'b0, pkt_cnt_q} + CW1'(1)) == {1'b0, num_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    num_d     = num_q;
    pkt_cnt_d = pkt_cnt_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    pend_d    = pend_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (RUN) begin
          num_d     = CFG_NUM_PKT;
          pkt_cnt_d = '0;
          err_d     = 1'b0;
          pend_d    = 1'b0;
          state_d   = (CFG_NUM_PKT == '0) ? S_FINISH : S_INJ1;
        end
      end
      S_INJ1: begin
        if (done_evt) pend_d = 1'b1;
        state_d = S_INJ2;
      end
      S_INJ2: begin
        if (done_evt) pend_d = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        pend_d = 1'b0;
        if (hit) begin
          pkt_cnt_d = (pkt_cnt_q == CNT_MAX) ? pkt_cnt_q : pkt_cnt_q + CNTW'(1);
          gap_d     = '0;
          if (last_pkt)             state_d = S_FINISH;
          else if (GAP_CYCLES == 0) state_d = S_INJ1;
          else                      state_d = S_GAP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if (wdog_d == WD_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_INJ1;
        else                   gap_d   = gap_q + GW'(1);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous completion or
    // watchdog expiry: no count, no error, straight to FINISH.
    if (ABORT && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
      state_d   = S_FINISH;
      pkt_cnt_d = pkt_cnt_q;
      err_d     = err_q;
      pend_d    = 1'b0;
    end

    // Outputs are registered versions of the next-state decode.
    start_d    = (state_d == S_INJ1);
    start2_d   = (state_d == S_INJ2);
    busy_d     = (state_d != S_IDLE);
    finished_d = (state_d == S_FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      pkt_cnt_q   <= '0;
      wdog_q      <= '0;
      gap_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      done_prev_q <= 1'b0;
      start_q     <= 1'b0;
      start2_q    <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      num_q       <= num_d;
      pkt_cnt_q   <= pkt_cnt_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      done_prev_q <= DONE;
      start_q     <= start_d;
      start2_q    <= start2_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  assign START       = start_q;
  assign START2      = start2_q;
  assign BUSY        = busy_q;
  assign FINISHED    = finished_q;
  assign TIMEOUT_ERR = err_q;
  assign PKT_CNT     = pkt_cnt_q;

`ifdef INJ_LOG_EN
  logic [DATAW-1:0] cap1_q, cap1_d;
  logic [DATAW-1:0] log1_q, log1_d;
  logic [DATAW-1:0] log2_q, log2_d;
  logic             log_valid_q, log_valid_d;

  // Operand 1 is staged in cap1 so both log words change on the same edge.
  always_comb begin
    cap1_d      = cap1_q;
    log1_d      = log1_q;
    log2_d      = log2_q;
    log_valid_d = 1'b0;
    if (state_q == S_INJ1) cap1_d = DATA_O1;
    if ((state_q == S_INJ2) && (state_d == S_WAIT_DONE)) begin
      log1_d      = cap1_q;
      log2_d      = DATA_O2;
      log_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap1_q      <= '0;
      log1_q      <= '0;
      log2_q      <= '0;
      log_valid_q <= 1'b0;
    end else begin
      cap1_q      <= cap1_d;
      log1_q      <= log1_d;
      log2_q      <= log2_d;
      log_valid_q <= log_valid_d;
    end
  end

  assign LOG_VALID = log_valid_q;
  assign LOG_DATA1 = log1_q;
  assign LOG_DATA2 = log2_q;
`else
  logic unused_data;
  assign unused_data = ^{DATA_O1, DATA_O2};

  assign LOG_VALID = 1'b0;
  assign LOG_DATA1 = '0;
  assign LOG_DATA2 = '0;
`endif

endmodule

// File: tb/tb_noc_inject_sequencer.sv
// Self-checking bench for noc_inject_sequencer (GAP_CYCLES=2, TIMEOUT_CYCLES=8).
// The reference model predicts, per sequence, the cycle of every START and
// START2 relative to RUN acceptance, the FINISHED cycle, the final packet
// count and the watchdog error, from per-packet DONE delays.
// DONE delay d means DONE is high d cycles after the START2 cycle.
module tb_noc_inject_sequencer;

  localparam int DATAW = 32;
  localparam int GAP   = 2;
  localparam int TMO   = 8;
  localparam int CNTW  = 16;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             RUN = 1'b0;
  logic             ABORT = 1'b0;
  logic             DONE = 1'b0;
  logic [CNTW-1:0]  CFG_NUM_PKT = '0;
  logic [DATAW-1:0] DATA_O1 = '0;
  logic [DATAW-1:0] DATA_O2 = '0;
  logic             START, START2, BUSY, FINISHED, TIMEOUT_ERR, LOG_VALID;
  logic [CNTW-1:0]  PKT_CNT;
  logic [DATAW-1:0] LOG_DATA1, LOG_DATA2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int               dly[16];
  logic [DATAW-1:0] v1[16];
  logic [DATAW-1:0] v2[16];
  int               abort_pkt = -1;

  noc_inject_sequencer #(
    .DATAW(DATAW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNTW(CNTW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ABORT(ABORT),
    .CFG_NUM_PKT(CFG_NUM_PKT), .START(START), .START2(START2), .DONE(DONE),
    .DATA_O1(DATA_O1), .DATA_O2(DATA_O2), .BUSY(BUSY), .FINISHED(FINISHED),
    .TIMEOUT_ERR(TIMEOUT_ERR), .PKT_CNT(PKT_CNT), .LOG_VALID(LOG_VALID),
    .LOG_DATA1(LOG_DATA1), .LOG_DATA2(LOG_DATA2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int first_diff(input int a[$], input int b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int q_at(input int a[$], input int i);
    return (i < a.size()) ? a[i] : -1;
  endfunction

  // Runs one sequence of num packets using dly/v1/v2/abort_pkt, predicts its
  // behaviour and scores the observed trace against the prediction.
  task automatic run_and_score(input string name, input int num);
    int exp_s[$], exp_s2[$], obs_s[$], obs_s2[$], obs_lc[$], exp_lc[$];
    logic [DATAW-1:0] obs_l1[$], obs_l2[$];
    int s, w, exp_fin, exp_cnt, r, fin_cyc, fin_n, busy_n, done_at, abort_at;
    int pk, pk1, idx, log_bad;
    logic exp_err, err_at_fin;

    // ---- reference model ----
    s = 0; exp_cnt = 0; exp_err = 1'b0; exp_fin = 0;
    for (int i = 0; i < num; i++) begin
      exp_s.push_back(s);
      exp_s2.push_back(s + 1);
      w = (dly[i] < 1) ? 1 : dly[i];
      if (i == abort_pkt) begin exp_fin = s + 2 + dly[i]; break; end
      if (dly[i] > TMO)   begin exp_err = 1'b1; exp_fin = s + 2 + TMO; break; end
      exp_cnt++;
      if (i == num - 1)   begin exp_fin = s + 2 + w; break; end
      s = s + 2 + w + GAP;
    end
    foreach (exp_s[i]) exp_lc.push_back(exp_s[i] + 2);

    // ---- stimulus and monitor ----
    @(negedge CLK);
    CFG_NUM_PKT = CNTW'(num);
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    r = cyc;
    fin_cyc = -1; fin_n = 0; busy_n = 0; done_at = -1000; abort_at = -1000;
    pk = 0; pk1 = 0; log_bad = 0; err_at_fin = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (START === 1'b1) begin
        obs_s.push_back(cyc - r);
        if (pk1 < 16) begin DATA_O1 = v1[pk1]; DATA_O2 = ~v2[pk1]; end
        pk1++;
      end
      if (START2 === 1'b1) begin
        obs_s2.push_back(cyc - r);
        if (pk < 16) begin
          done_at = cyc + dly[pk];
          if (pk == abort_pkt) abort_at = done_at;
          DATA_O1 = $urandom;
          DATA_O2 = v2[pk];
        end
        pk++;
      end
      if (FINISHED === 1'b1) begin
        if (fin_n == 0) begin fin_cyc = cyc - r; err_at_fin = TIMEOUT_ERR; end
        fin_n++;
      end
      if (BUSY === 1'b1) busy_n++;
`ifdef INJ_LOG_EN
      if (LOG_VALID === 1'b1) begin
        obs_lc.push_back(cyc - r);
        obs_l1.push_back(LOG_DATA1);
        obs_l2.push_back(LOG_DATA2);
      end
`else
      if (LOG_VALID !== 1'b0 || LOG_DATA1 !== '0 || LOG_DATA2 !== '0) log_bad++;
`endif
      DONE  = (cyc == done_at);
      ABORT = (cyc == abort_at);
      if (fin_n > 0 && (cyc - r) >= fin_cyc + 2) break;
      @(negedge CLK);
    end
    DONE = 1'b0;
    ABORT = 1'b0;

    // ---- scoring ----
    checks++;
    idx = first_diff(obs_s, exp_s);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s start_cycles[%0d]: got %0d expected %0d (count got %0d expected %0d)",
               name, idx, q_at(obs_s, idx), q_at(exp_s, idx), obs_s.size(), exp_s.size());
    end
    checks++;
    idx = first_diff(obs_s2, exp_s2);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s start2_cycles[%0d]: got %0d expected %0d (count got %0d expected %0d)",
               name, idx, q_at(obs_s2, idx), q_at(exp_s2, idx), obs_s2.size(), exp_s2.size());
    end
    checks++;
    if (fin_cyc !== exp_fin) begin
      errors++;
      $display("FAIL %s finished_cycle: got %0d expected %0d", name, fin_cyc, exp_fin);
    end
    checks++;
    if (fin_n !== 1) begin
      errors++;
      $display("FAIL %s finished_pulses: got %0d expected 1", name, fin_n);
    end
    checks++;
    if (err_at_fin !== exp_err) begin
      errors++;
      $display("FAIL %s timeout_err_at_finish: got %0b expected %0b", name, err_at_fin, exp_err);
    end
    checks++;
    if (TIMEOUT_ERR !== exp_err) begin
      errors++;
      $display("FAIL %s timeout_err_sticky: got %0b expected %0b", name, TIMEOUT_ERR, exp_err);
    end
    checks++;
    if (PKT_CNT !== CNTW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s pkt_cnt: got %0d expected %0d", name, PKT_CNT, exp_cnt);
    end
    checks++;
    if (busy_n !== exp_fin + 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_fin + 1);
    end
`ifdef INJ_LOG_EN
    checks++;
    idx = first_diff(obs_lc, exp_lc);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s log_valid_cycles[%0d]: got %0d expected %0d", name, idx,
               q_at(obs_lc, idx), q_at(exp_lc, idx));
    end
    for (int i = 0; i < obs_l1.size() && i < exp_lc.size(); i++)
      if (obs_l1[i] !== v1[i] || obs_l2[i] !== v2[i]) log_bad++;
    checks++;
    if (log_bad != 0) begin
      errors++;
      $display("FAIL %s log_data: %0d bad entries, first got %h/%h expected %h/%h", name,
               log_bad, obs_l1.size() > 0 ? obs_l1[0] : '0, obs_l2.size() > 0 ? obs_l2[0] : '0,
               v1[0], v2[0]);
    end
`else
    checks++;
    if (log_bad != 0) begin
      errors++;
      $display("FAIL %s log_outputs_tied: got %0d nonzero cycles expected 0", name, log_bad);
    end
`endif
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < 16; i++) begin
      dly[i] = $urandom_range(hi, lo);
      v1[i]  = $urandom;
      v2[i]  = $urandom;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({START, START2, BUSY, FINISHED, TIMEOUT_ERR, LOG_VALID} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {START, START2, BUSY, FINISHED, TIMEOUT_ERR, LOG_VALID});
    end
    checks++;
    if (PKT_CNT !== '0 || LOG_DATA1 !== '0 || LOG_DATA2 !== '0) begin
      errors++;
      $display("FAIL reset_values: got pkt=%0d log1=%h log2=%h expected all 0",
               PKT_CNT, LOG_DATA1, LOG_DATA2);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_ten_packets;
    fill_random(3, 3);
    abort_pkt = -1;
    run_and_score("ten_packets", 10);
  endtask

  task automatic test_timeout;
    fill_random(20, 20);
    abort_pkt = -1;
    run_and_score("timeout", 1);
  endtask

  task automatic test_pending;
    fill_random(0, 0);
    abort_pkt = -1;
    run_and_score("pending_done", 4);
  endtask

  task automatic test_zero_count;
    abort_pkt = -1;
    run_and_score("zero_count", 0);
  endtask

  task automatic test_abort;
    fill_random(3, 3);
    abort_pkt = 2;
    run_and_score("abort_with_done", 5);
    abort_pkt = -1;
  endtask

  task automatic test_log;
    fill_random(1, 4);
    v1[0] = 32'h0000_00A5;
    v2[0] = 32'h0000_005A;
    abort_pkt = -1;
    run_and_score("operand_log", 2);
  endtask

  task automatic test_random;
    int n;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(7, 1);
      fill_random(0, 10);
      abort_pkt = -1;
      if ($urandom_range(3, 0) == 0) begin
        abort_pkt = $urandom_range(n - 1, 0);
        dly[abort_pkt] = $urandom_range(TMO, 1);
      end
      run_and_score($sformatf("random_%0d", k), n);
    end
    abort_pkt = -1;
  endtask

  task automatic test_async_reset;
    @(negedge CLK);
    CFG_NUM_PKT = CNTW'(3);
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({START, START2, BUSY} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_cut: got start/start2/busy=%b expected 000",
               {START, START2, BUSY});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({START, BUSY, FINISHED} !== 3'b000 || PKT_CNT !== '0) begin
      errors++;
      $display("FAIL async_reset_idle: got start/busy/fin=%b pkt=%0d expected 000 and 0",
               {START, BUSY, FINISHED}, PKT_CNT);
    end
  endtask

  initial begin
    #1 RST_N = 1'b0;
    test_reset();
    test_ten_packets();
    test_timeout();
    test_pending();
    test_zero_count();
    test_abort();
    test_log();
    test_random();
    test_async_reset();
    test_ten_packets();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
